pixel_ram_ctrl: RTL and testbench
=================================

Name: pixel_ram_ctrl

Overview:
Parametrised single-clock palette-index RAM for backgrounds, areas and sprites, replacing the fixed-size per-asset RAMs. It adds configurable width, depth and read latency, a read-valid pipeline, out-of-range address protection, and a hardware fill engine that clears or paints the whole memory. It sits between the frame/sprite address generators and the palette lookup in the video path.

Parameters:
DATA_W, 4, palette index width in bits
DEPTH, 69520, number of words
ADDR_W, 17, address width; must satisfy 2**ADDR_W >= DEPTH
RD_LAT, 1, read latency in cycles; legal values 1 or 2
OOR_VALUE, 0, data returned for reads at address >= DEPTH
INIT_FILE, "txt_files/Background1.txt", hex image used only when SPRITE_RAM_INIT_EN is defined

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_dropped  output  1  one-cycle pulse: a write was ignored (fill busy or out of range)
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data, valid when rd_valid=1
rd_valid  output  1  read data qualifier
fill_start  input  1  start fill engine (sampled in IDLE only)
fill_value  input  DATA_W  value written by fill engine, captured at fill_start
fill_busy  output  1  fill engine active
fill_done  output  1  one-cycle pulse on the final fill write

Behaviour:
- Reset (Reset_n=0, async): rd_data=0, rd_valid=0, wr_dropped=0, fill_busy=0, fill_done=0, fill counter=0, read pipeline flushed. Memory contents are not reset. FSM goes to IDLE (or AUTOCLR, see Optional Feature).
- Read: rd_en at edge N -> rd_valid=1 and rd_data at edge N+RD_LAT. Back-to-back reads supported every cycle. rd_valid is 0 in any cycle with no matching request. rd_data holds its last value when rd_valid=0.
- Out-of-range read (rd_addr >= DEPTH): still produces rd_valid with rd_data=OOR_VALUE at the same latency. Memory is not accessed.
- Write: wr_en with wr_addr < DEPTH in IDLE writes memory at that edge.
- Dropped write: wr_addr >= DEPTH, or wr_en while fill_busy=1. The write is not performed and wr_dropped=1 on the following cycle.
- Same-address read and write in the same cycle: read returns old data (read-before-write).
- FSM states:
  - IDLE -> FILL on fill_start=1. Captures fill_value and sets counter=0.
  - FILL: writes fill_value at address counter each cycle and increments counter. fill_busy=1 for exactly DEPTH cycles, starting the cycle after fill_start. On the write at counter=DEPTH-1, fill_done pulses and the FSM returns to IDLE with counter=0.
  - AUTOCLR: identical to FILL with value 0. Entered only from reset.
- fill_start in FILL/AUTOCLR is ignored, with no restart.
- Reads are serviced normally during fill and return current memory contents, which may be partially filled.
- Reset asserted mid-fill aborts immediately. Written words remain written; the counter is cleared.

Optional Feature:
SPRITE_RAM_INIT_EN
- Defined: memory is preloaded from INIT_FILE by $readmemh at elaboration. Reset exits to IDLE.
- Undefined: no file load. On Reset_n deassertion the FSM enters AUTOCLR, clearing all DEPTH words to 0. fill_busy=1 during the clear; fill_done pulses at the end; writes are dropped during the clear.

Test Plan:
- DEPTH=16, DATA_W=4, RD_LAT=2, init file defined: write 0xA at addr 5, then rd_en addr 5 at cycle N -> rd_valid=1, rd_data=0xA at cycle N+2; rd_valid=0 at N+1 and N+3.
- Read rd_addr=20 (>=DEPTH), OOR_VALUE=0xF -> rd_data=0xF with rd_valid at N+RD_LAT. Write to addr 20 -> wr_dropped pulse; reading addr 4 is unchanged.
- fill_start with fill_value=0x3 -> fill_busy high 16 cycles; fill_done pulses on the 16th; all 16 addresses read back 0x3. A wr_en mid-fill produces wr_dropped=1, and that address still reads 0x3.
- Same-cycle write 0x7 and read of addr 2 holding 0x1 -> read returns 0x1; the next read returns 0x7.
- Reset_n pulled low at fill cycle 8 -> all outputs 0 asynchronously. After release in IDLE: addrs 0-7 hold the fill value, addrs 8-15 keep prior contents.
- Init file undefined: after reset release, fill_busy=1 for 16 cycles, then fill_done; every address reads 0x0.

Source files
------------

// File: rtl/pixel_ram_ctrl.sv
// Parametrised palette-index RAM with a read-valid pipeline, out-of-range guards and a fill engine.
// Optional macro SPRITE_RAM_INIT_EN: preload from INIT_FILE instead of clearing the RAM after reset.
module pixel_ram_ctrl #(
    parameter int                DATA_W    = 4,
    parameter int                DEPTH     = 69520,
    parameter int                ADDR_W    = 17,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] OOR_VALUE = {DATA_W{1'b0}},
    parameter string             INIT_FILE = "txt_files/Background1.txt"
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_dropped,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  ZERO_IDX = {IDX_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        FILL    = 2'd2,
        AUTOCLR = 2'd3
    } state_t;

`ifdef SPRITE_RAM_INIT_EN
    localparam state_t RST_STATE = IDLE;
`else
    // ARM spends the first post-reset cycle so fill_busy rises one edge after release.
    localparam state_t RST_STATE = ARM;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [DATA_W-1:0] fill_val_q;
    logic              fill_busy_q;
    logic              fill_done_q;
    logic              wr_dropped_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic              filling_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_wa_s;
    logic [DATA_W-1:0] mem_wd_s;
    logic [DATA_W-1:0] rd_raw_s;

    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_A);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_A);
    assign filling_s     = (state_q == FILL) || (state_q == AUTOCLR);

    // Write-port arbitration: the fill engine owns the port while active.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = ZERO_IDX;
        mem_wd_s = {DATA_W{1'b0}};
        if (filling_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = cnt_q;
            mem_wd_s = fill_val_q;
        end else if ((state_q == IDLE) && wr_en && wr_in_range_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wr_addr[IDX_W-1:0];
            mem_wd_s = wr_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Memory array write; contents survive reset.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    // Read source; out-of-range addresses never touch the array.
    always_comb begin
        rd_raw_s = OOR_VALUE;
        if (rd_in_range_s) begin
            rd_raw_s = mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_raw_s = OOR_VALUE;
        end
    end

    // Fill/autoclear FSM with registered status outputs and write-drop flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= RST_STATE;
            cnt_q        <= ZERO_IDX;
            fill_val_q   <= {DATA_W{1'b0}};
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= wr_en && ((state_q != IDLE) || !wr_in_range_s);
            case (state_q)
                IDLE: begin
                    cnt_q <= ZERO_IDX;
                    if (fill_start) begin
                        state_q     <= FILL;
                        fill_val_q  <= fill_value;
                        fill_busy_q <= 1'b1;
                        fill_done_q <= (LAST_IDX == ZERO_IDX);
                    end else begin
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b0;
                    end
                end
                ARM: begin
                    state_q     <= AUTOCLR;
                    fill_val_q  <= {DATA_W{1'b0}};
                    cnt_q       <= ZERO_IDX;
                    fill_busy_q <= 1'b1;
                    fill_done_q <= (LAST_IDX == ZERO_IDX);
                end
                FILL, AUTOCLR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= IDLE;
                        cnt_q       <= ZERO_IDX;
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q + IDX_W'(1);
                        fill_done_q <= ((cnt_q + IDX_W'(1)) == LAST_IDX);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= ZERO_IDX;
                    fill_busy_q <= 1'b0;
                    fill_done_q <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p_valid_q;
            logic [DATA_W-1:0] p_data_q;
            // Two-stage read pipeline; output data only moves with a valid beat.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    p_valid_q  <= 1'b0;
                    p_data_q   <= {DATA_W{1'b0}};
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= {DATA_W{1'b0}};
                end else begin
                    p_valid_q  <= rd_en;
                    p_data_q   <= rd_raw_s;
                    rd_valid_q <= p_valid_q;
                    if (p_valid_q) begin
                        rd_data_q <= p_data_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read; output data only moves with a valid beat.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= {DATA_W{1'b0}};
                end else begin
                    rd_valid_q <= rd_en;
                    if (rd_en) begin
                        rd_data_q <= rd_raw_s;
                    end
                end
            end
        end
    endgenerate

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign wr_dropped = wr_dropped_q;
    assign fill_busy  = fill_busy_q;
    assign fill_done  = fill_done_q;
endmodule

// File: tb/tb_pixel_ram_ctrl.sv
// Directed plus random checks of pixel_ram_ctrl against a cycle-level behavioural model.
module tb_pixel_ram_ctrl;
    localparam int        DW    = 4;
    localparam int        DEPTH = 16;
    localparam int        AW    = 5;
    localparam int        LAT   = 2;
    localparam logic [3:0] OOR  = 4'hF;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_dropped;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic          fill_busy;
    logic          fill_done;

    pixel_ram_ctrl #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(LAT), .OOR_VALUE(OOR)
    ) dut (
        .Clk(clk), .Reset_n(Reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dropped(wr_dropped),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int val; } rd_t;

    int  mem_m [DEPTH];
    int  fill_left = 0;
    int  fval = 0;
    bit  arm = 1'b0;
    int  cyc = 0;
    int  last_data = 0;
    rd_t pend [$];
    int  comps = 0;
    int  fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check in-cycle status, advance the model, clock, check registered results.
    task automatic cycle();
        int  rv;
        bit  was_idle;
        bit  exp_drop;
        bit  exp_valid;
        rd_t e;
        chk("fill_busy", {31'd0, fill_busy}, (fill_left > 0) ? 32'd1 : 32'd0);
        chk("fill_done", {31'd0, fill_done}, (fill_left == 1) ? 32'd1 : 32'd0);
        if (rd_en) begin
            rv = (int'(rd_addr) >= DEPTH) ? int'(OOR) : mem_m[rd_addr];
            pend.push_back('{cyc + LAT, rv});
        end
        was_idle = (fill_left == 0) && !arm;
        exp_drop = wr_en && (!was_idle || int'(wr_addr) >= DEPTH);
        if (fill_left > 0) begin
            mem_m[DEPTH - fill_left] = fval;
            fill_left--;
        end else if (was_idle && wr_en && int'(wr_addr) < DEPTH) begin
            mem_m[wr_addr] = int'(wr_data);
        end
        if (arm) begin
            arm = 1'b0;
            fill_left = DEPTH;
            fval = 0;
        end else if (was_idle && fill_start) begin
            fill_left = DEPTH;
            fval = int'(fill_value);
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            last_data = e.val;
            exp_valid = 1'b1;
        end
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
        chk("rd_data", {28'd0, rd_data}, last_data);
        chk("wr_dropped", {31'd0, wr_dropped}, {31'd0, exp_drop});
        wr_en = 1'b0;
        rd_en = 1'b0;
        fill_start = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1;
        rd_addr = AW'(a);
        cycle();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        cycle();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(i);
        cycle();
        cycle();
    endtask

    task automatic wait_fill();
        for (int k = 0; k < DEPTH + 4 && (fill_left > 0 || arm); k++) cycle();
        chk("fill_finished", {31'd0, fill_busy}, 32'd0);
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_wr_dropped", {31'd0, wr_dropped}, 32'd0);
        chk("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
        chk("rst_fill_done", {31'd0, fill_done}, 32'd0);
        pend.delete();
        last_data = 0;
        fill_left = 0;
        arm = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
`ifndef SPRITE_RAM_INIT_EN
        arm = 1'b1;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        #2;
        apply_reset();
        wait_fill();
`ifdef SPRITE_RAM_INIT_EN
        fill_start = 1'b1;
        fill_value = 4'h0;
        cycle();
        wait_fill();
`endif
        read_all();

        // Basic write then latency-2 read.
        wr(5, 4'hA);
        rd(5);
        cycle();
        cycle();
        cycle();

        // Out-of-range read and dropped out-of-range write.
        rd(20);
        wr(20, 4'h3);
        rd(4);
        cycle();
        cycle();

        // Fill with 0x3, plus a dropped write during the fill.
        fill_start = 1'b1;
        fill_value = 4'h3;
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 6) begin
                wr_en = 1'b1;
                wr_addr = 5'd2;
                wr_data = 4'hC;
            end
            cycle();
        end
        read_all();

        // Read-before-write on the same address.
        wr(2, 4'h1);
        wr_en = 1'b1;
        wr_addr = 5'd2;
        wr_data = 4'h7;
        rd(2);
        rd(2);
        cycle();
        cycle();

        // Distinct contents, then a fill aborted by reset after 8 writes.
        for (int i = 0; i < DEPTH; i++) wr(i, i);
        fill_start = 1'b1;
        fill_value = 4'h5;
        cycle();
        for (int i = 0; i < 8; i++) cycle();
        apply_reset();
        wait_fill();
        read_all();

        // Random traffic with occasional fills.
        for (int i = 0; i < 300; i++) begin
            rd_en = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, 19));
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 19));
            wr_data = DW'($urandom_range(0, 15));
            fill_start = ($urandom_range(0, 39) == 0);
            fill_value = DW'($urandom_range(0, 15));
            cycle();
        end
        wait_fill();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule
